// File: rtl/button_digit_source.sv
// Debounced push-button stepper: press, hold and auto-repeat events advance a 4-bit hex digit
// that is also decoded to an active-low seven-segment pattern for the renderer.
module button_digit_source #(
    parameter int DEBOUNCE_CYCLES = 300000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic       clear,
    output logic [3:0] digit,
    output logic [6:0] seven,
    output logic       step,
    output logic       held
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] T_ZERO   = TW'(0);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_HELD   = 3'd2,
        S_REPEAT = 3'd3,
        S_REL    = 3'd4
    } state_t;

    // Active-low segment pattern, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic          r_sync1;
    logic          r_btn_s;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_digit;
    logic          r_step;
    logic          r_held;

    state_t        w_state_nx;
    logic [TW-1:0] w_timer_nx;
    logic          w_fire;
    logic [3:0]    w_digit_nx;
    logic          w_held_nx;

    // Next-state, timer and step decision for the debounce / hold / repeat machine.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nx = S_ARM;
                    w_timer_nx = T_ONE;
                end else begin
                    w_timer_nx = T_ZERO;
                end
            end
            S_ARM: begin
                if (!r_btn_s) begin
                    w_state_nx = S_IDLE;
                    w_timer_nx = T_ZERO;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nx = S_HELD;
                    w_timer_nx = T_ZERO;
                    w_fire     = 1'b1;
                end else begin
                    w_timer_nx = r_timer + T_ONE;
                end
            end
            S_HELD: begin
                if (!r_btn_s) begin
                    w_state_nx = S_REL;
                    w_timer_nx = T_ZERO;
                end else if (r_timer == HLD_LAST) begin
                    w_state_nx = S_REPEAT;
                    w_timer_nx = T_ZERO;
                    w_fire     = 1'b1;
                end else begin
                    w_timer_nx = r_timer + T_ONE;
                end
            end
            S_REPEAT: begin
                if (!r_btn_s) begin
                    w_state_nx = S_REL;
                    w_timer_nx = T_ZERO;
                end else if (r_timer == REP_LAST) begin
                    w_timer_nx = T_ZERO;
                    w_fire     = 1'b1;
                end else begin
                    w_timer_nx = r_timer + T_ONE;
                end
            end
            S_REL: begin
                // A bounce during release restarts the quiet window.
                if (r_btn_s) begin
                    w_timer_nx = T_ZERO;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nx = S_IDLE;
                    w_timer_nx = T_ZERO;
                end else begin
                    w_timer_nx = r_timer + T_ONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_timer_nx = T_ZERO;
            end
        endcase
    end

    // Digit update (clear has priority over a step) and the held flag for the next state.
    always_comb begin
        w_digit_nx = r_digit;
        if (clear) begin
            w_digit_nx = 4'h0;
        end else if (w_fire) begin
            w_digit_nx = r_digit + 4'h1;
        end else begin
            w_digit_nx = r_digit;
        end
        w_held_nx = (w_state_nx == S_HELD) || (w_state_nx == S_REPEAT);
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
            r_state <= S_IDLE;
            r_timer <= T_ZERO;
            r_digit <= 4'h0;
            r_step  <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_btn_s <= r_sync1;
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_digit <= w_digit_nx;
            r_step  <= w_fire;
            r_held  <= w_held_nx;
        end
    end

    assign digit = r_digit;
    assign seven = seg_decode(r_digit);
    assign step  = r_step;
    assign held  = r_held;

endmodule
